// File: rtl/dither_pkg.sv
// Shared types and constants for the RGB dither scheduler.
//   state_e : scheduler FSM states (one state per colour channel).
//   chan_e  : colour channel served by the shared quantizer.
//   IN_W / OUT_W : per-channel input / output widths.
//   ERR_W   : width of a signed error register (range -8..+15).
//   SUM_W   : width of the pixel+error intermediate sum.
//   THRESHOLD : rounding point on the low nibble.
package dither_pkg;

    localparam int IN_W      = 8;
    localparam int OUT_W     = 4;
    localparam int ERR_W     = 5;
    localparam int SUM_W     = 10;
    localparam int THRESHOLD = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CH_R = 3'd1,
        ST_CH_G = 3'd2,
        ST_CH_B = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CHAN_R = 2'd0,
        CHAN_G = 2'd1,
        CHAN_B = 2'd2
    } chan_e;

endpackage

// File: rtl/dither_quant.sv
// Combinational error-diffusion quantizer for one 8-bit channel.
//   in_i       : 8-bit channel value.
//   err_i      : signed carried error (-8..+15).
//   q_o        : 4-bit quantized value, min(15, (S + 8) >> 4).
//   err_next_o : signed residual S - 16*q.
// S is in_i + err_i clamped to 0..255.
module dither_quant
    import dither_pkg::*;
(
    input  logic [IN_W-1:0]         in_i,
    input  logic signed [ERR_W-1:0] err_i,
    output logic [OUT_W-1:0]        q_o,
    output logic signed [ERR_W-1:0] err_next_o
);

    logic [SUM_W-1:0] sum;
    logic [IN_W-1:0]  sat;
    logic [3:0]       hi;
    logic [3:0]       lo;
    logic             round_up;

    // Two's-complement sum; bit 9 is the sign, bit 8 flags a value above 255
    // (the sum never leaves -8..270, so these two bits fully decide the clamp).
    assign sum = {{(SUM_W-IN_W){1'b0}}, in_i} + {{(SUM_W-ERR_W){err_i[ERR_W-1]}}, err_i};

    always_comb begin
        if (sum[SUM_W-1]) begin
            sat = '0;
        end else if (sum[IN_W]) begin
            sat = '1;
        end else begin
            sat = sum[IN_W-1:0];
        end
    end

    assign hi = sat[7:4];
    assign lo = sat[3:0];

    // (S + 8) >> 4 is hi plus one when the low nibble reaches the threshold;
    // hi == 15 is where min(15, ...) caps the result instead.
    assign round_up = (lo >= 4'(THRESHOLD)) && (hi != 4'hF);

    assign q_o = hi + {3'b000, round_up};

    // S - 16*q is lo when not rounded up, else lo - 16, i.e. {1, lo} in 5 bits.
    assign err_next_o = $signed({round_up, lo});

endmodule

// File: rtl/dither_scheduler.sv
// RGB888 -> RGB444 error-diffusion dither scheduler.
// One quantizer is time-shared over R, G, B (one channel per cycle); each
// channel carries its residual error to the next pixel on the line.
// Ports:
//   clk, rst          : clock, synchronous active-high reset.
//   line_start        : pulse; zeroes all three error registers.
//   pix_valid/ready   : input pixel handshake; pix_rgb/pix_visible sampled on it.
//   out_valid/ready   : output pixel handshake; out_rgb held while valid.
//   dbg_state_o       : current FSM state for observation.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// never depends on ready, and out_rgb is stable while out_valid is high.
module dither_scheduler
    import dither_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_start,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [3*IN_W-1:0]    pix_rgb,
    input  logic                 pix_visible,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*OUT_W-1:0]   out_rgb,
    output state_e               dbg_state_o
);

    state_e state_q, state_d;
    logic [3*IN_W-1:0]  pix_q;
    logic               vis_q;
    logic [3*OUT_W-1:0] out_q;
    logic signed [ERR_W-1:0] err_r_q, err_g_q, err_b_q;

    logic                    load;
    logic                    chan_active;
    chan_e                   chan;
    logic [IN_W-1:0]         quant_in;
    logic signed [ERR_W-1:0] quant_err;
    logic [OUT_W-1:0]        quant_q;
    logic signed [ERR_W-1:0] quant_err_next;
    logic [OUT_W-1:0]        q_eff;
    logic signed [ERR_W-1:0] err_wb;

    // Channel mux in front of the single quantizer.
    always_comb begin
        chan        = CHAN_R;
        chan_active = 1'b0;
        case (state_q)
            ST_CH_R: begin chan = CHAN_R; chan_active = 1'b1; end
            ST_CH_G: begin chan = CHAN_G; chan_active = 1'b1; end
            ST_CH_B: begin chan = CHAN_B; chan_active = 1'b1; end
            default: begin chan = CHAN_R; chan_active = 1'b0; end
        endcase
    end

    always_comb begin
        quant_in  = pix_q[23:16];
        quant_err = err_r_q;
        case (chan)
            CHAN_G:  begin quant_in = pix_q[15:8]; quant_err = err_g_q; end
            CHAN_B:  begin quant_in = pix_q[7:0];  quant_err = err_b_q; end
            default: begin quant_in = pix_q[23:16]; quant_err = err_r_q; end
        endcase
    end

    dither_quant u_quant (
        .in_i       (quant_in),
        .err_i      (quant_err),
        .q_o        (quant_q),
        .err_next_o (quant_err_next)
    );

    // Invisible pixels output black and reset the carried error.
    assign q_eff  = vis_q ? quant_q : '0;
    assign err_wb = vis_q ? quant_err_next : '0;

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    load    = 1'b1;
                    state_d = ST_CH_R;
                end
            end
            ST_CH_R: state_d = ST_CH_G;
            ST_CH_G: state_d = ST_CH_B;
            ST_CH_B: state_d = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                pix_ready = out_ready;
                if (out_ready) begin
                    // Output leaves this edge; a waiting pixel starts at once.
                    if (pix_valid) begin
                        load    = 1'b1;
                        state_d = ST_CH_R;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pix_q   <= '0;
            vis_q   <= 1'b0;
            out_q   <= '0;
            err_r_q <= '0;
            err_g_q <= '0;
            err_b_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                pix_q <= pix_rgb;
                vis_q <= pix_visible;
            end
            if (chan_active) begin
                case (chan)
                    CHAN_G:  out_q[7:4]  <= q_eff;
                    CHAN_B:  out_q[3:0]  <= q_eff;
                    default: out_q[11:8] <= q_eff;
                endcase
            end
            // line_start takes priority over the channel's own write-back.
            if (line_start) begin
                err_r_q <= '0;
                err_g_q <= '0;
                err_b_q <= '0;
            end else if (chan_active) begin
                case (chan)
                    CHAN_G:  err_g_q <= err_wb;
                    CHAN_B:  err_b_q <= err_wb;
                    default: err_r_q <= err_wb;
                endcase
            end
        end
    end

    assign out_rgb     = out_q;
    assign dbg_state_o = state_q;

endmodule
